// File: rtl/ram_interface.sv
`default_nettype none
// ============================================================================
// Module      : ram_interface
// Description : Backing-memory stage for the cache. Accepts one read or write
//               request at a time, waits a fixed LATENCY cycles, then performs
//               the array access and pulses resp_valid for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_interface #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_data,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  busy
);

    localparam int         c_depth    = 2 ** ADDR_WIDTH;
    // With a single-cycle latency the access happens on the accepting edge,
    // so the WAIT state is never visited.
    localparam bit         c_single   = (LATENCY == 1);
    localparam logic [7:0] c_lat_init = 8'(LATENCY - 1);

    // The latency counter is 8 bits wide; anything outside 1..255 cannot be
    // represented and would silently corrupt the response timing.
    generate
        if (LATENCY < 1 || LATENCY > 255) begin : g_latency_illegal
            $error("ram_interface: LATENCY must lie within 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_data;
    logic [WIDTH-1:0]      r_resp_data;
    logic [WIDTH-1:0]      r_storage [0:c_depth-1];

    logic                  w_ready;
    logic                  w_resp_valid;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_acc_we;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [WIDTH-1:0]      w_acc_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode, handshake outputs and access strobe.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_resp_valid = 1'b0;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (c_single) begin
                        w_state_next = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_count == 8'd1) begin
                    w_state_next = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The access uses the live inputs when it happens on the accepting edge
    // (single-cycle latency) and the captured copy otherwise.
    assign w_acc_we   = (r_state == S_IDLE) ? req_we   : r_we;
    assign w_acc_addr = (r_state == S_IDLE) ? req_addr : r_addr;
    assign w_acc_data = (r_state == S_IDLE) ? req_data : r_data;

    // Latency counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (w_accept) begin
            r_count <= c_lat_init;
        end else if (r_state == S_WAIT && r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    // Capture the request so later input changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_we   <= req_we;
            r_addr <= req_addr;
            r_data <= req_data;
        end
    end

    // Storage array: cleared by reset, written on the edge entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_storage[i] <= '0;
            end
        end else if (w_enter_resp && w_acc_we) begin
            r_storage[w_acc_addr] <= w_acc_data;
        end
    end

    // Read data is loaded on entry to RESP and forced back to zero after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_data <= '0;
        end else if (w_enter_resp && !w_acc_we) begin
            r_resp_data <= r_storage[w_acc_addr];
        end else begin
            r_resp_data <= '0;
        end
    end

    assign req_ready  = w_ready;
    assign busy       = ~w_ready;
    assign resp_valid = w_resp_valid;
    assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_interface
// Description : Self-checking bench for ram_interface. A LATENCY=4 instance
//               runs directed and random transactions with junk traffic while
//               busy; a LATENCY=1 instance covers the minimum-latency path.
//               Expected values come from a plain word-array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_interface;

    localparam int W  = 8;
    localparam int AW = 8;
    localparam int L  = 4;

    logic r_clk = 1'b0;
    logic r_rst = 1'b0;
    always #5 r_clk = ~r_clk;

    // LATENCY=4 instance signals
    logic          r_valid = 1'b0;
    logic          r_we    = 1'b0;
    logic [AW-1:0] r_addr  = '0;
    logic [W-1:0]  r_data  = '0;
    logic          w_ready, w_resp_valid, w_busy;
    logic [W-1:0]  w_resp_data;

    // LATENCY=1 instance signals
    logic          r1_valid = 1'b0;
    logic          r1_we    = 1'b0;
    logic [AW-1:0] r1_addr  = '0;
    logic [W-1:0]  r1_data  = '0;
    logic          w1_ready, w1_resp_valid, w1_busy;
    logic [W-1:0]  w1_resp_data;

    ram_interface #(.WIDTH(W), .ADDR_WIDTH(AW), .LATENCY(L)) dut (
        .clk        (r_clk),
        .rst        (r_rst),
        .req_valid  (r_valid),
        .req_we     (r_we),
        .req_addr   (r_addr),
        .req_data   (r_data),
        .req_ready  (w_ready),
        .resp_valid (w_resp_valid),
        .resp_data  (w_resp_data),
        .busy       (w_busy)
    );

    ram_interface #(.WIDTH(W), .ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
        .clk        (r_clk),
        .rst        (r_rst),
        .req_valid  (r1_valid),
        .req_we     (r1_we),
        .req_addr   (r1_addr),
        .req_data   (r1_data),
        .req_ready  (w1_ready),
        .resp_valid (w1_resp_valid),
        .resp_data  (w1_resp_data),
        .busy       (w1_busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference memories: one word per address, zero after reset.
    logic [W-1:0] mem  [0:255];
    logic [W-1:0] mem1 [0:255];

    task automatic clear_models();
        for (int i = 0; i < 256; i++) begin
            mem[i]  = '0;
            mem1[i] = '0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY=4 instance, starting in an idle cycle
    // (#1 after an edge). While busy, optionally hold a junk request.
    task automatic req4(input logic we, input logic [AW-1:0] addr, input logic [W-1:0] data,
                        input logic junk, input logic jwe, input logic [AW-1:0] jaddr,
                        input logic [W-1:0] jdata);
        check("idle_ready", w_ready, 1);
        check("idle_busy", w_busy, 0);
        r_valid = 1'b1; r_we = we; r_addr = addr; r_data = data;
        @(posedge r_clk); #1;
        if (junk) begin
            r_valid = 1'b1; r_we = jwe; r_addr = jaddr; r_data = jdata;
        end else begin
            r_valid = 1'b0; r_addr = jaddr; r_data = jdata;
        end
        for (int k = 1; k <= L; k++) begin
            check("wait_ready", w_ready, 0);
            check("wait_busy", w_busy, 1);
            check("resp_valid", w_resp_valid, (k == L) ? 1 : 0);
            check("resp_data", w_resp_data, (k == L && !we) ? mem[addr] : 0);
            if (k == L) r_valid = 1'b0;
            @(posedge r_clk); #1;
        end
        if (we) mem[addr] = data;
        check("after_ready", w_ready, 1);
        check("after_valid", w_resp_valid, 0);
        check("after_data", w_resp_data, 0);
    endtask

    // One transaction on the LATENCY=1 instance.
    task automatic req1(input logic we, input logic [AW-1:0] addr, input logic [W-1:0] data);
        check("l1_idle_ready", w1_ready, 1);
        r1_valid = 1'b1; r1_we = we; r1_addr = addr; r1_data = data;
        @(posedge r_clk); #1;
        r1_valid = 1'b0;
        check("l1_ready", w1_ready, 0);
        check("l1_busy", w1_busy, 1);
        check("l1_resp_valid", w1_resp_valid, 1);
        check("l1_resp_data", w1_resp_data, we ? 0 : mem1[addr]);
        @(posedge r_clk); #1;
        if (we) mem1[addr] = data;
        check("l1_after_ready", w1_ready, 1);
        check("l1_after_valid", w1_resp_valid, 0);
        check("l1_after_data", w1_resp_data, 0);
    endtask

    initial begin
        clear_models();

        // Asynchronous reset mid-cycle, observed before any clock edge.
        #2 r_rst = 1'b1;
        #1;
        check("rst_ready", w_ready, 1);
        check("rst_valid", w_resp_valid, 0);
        check("rst_data", w_resp_data, 0);
        check("rst_busy", w_busy, 0);
        check("rst1_ready", w1_ready, 1);
        repeat (2) @(posedge r_clk);
        #3 r_rst = 1'b0;
        @(posedge r_clk); #1;

        // Write then read back at LATENCY=4.
        req4(1'b1, 8'h12, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
        req4(1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        // A write held while busy must be ignored.
        req4(1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 8'h12, 8'h3C);
        // Changing the address during WAIT must not affect the read.
        req4(1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 8'h34, 8'h00);
        check("hold_a5", mem[8'h12], 8'hA5);

        // Minimum latency: unwritten address, then write/read back.
        req1(1'b0, 8'h00, 8'h00);
        req1(1'b1, 8'h05, 8'h5A);
        req1(1'b0, 8'h05, 8'h00);

        // Reset while a write is outstanding.
        r_valid = 1'b1; r_we = 1'b1; r_addr = 8'h20; r_data = 8'h77;
        @(posedge r_clk); #1;
        r_valid = 1'b0;
        @(posedge r_clk); #1;
        r_rst = 1'b1;
        #1;
        check("midrst_ready", w_ready, 1);
        check("midrst_valid", w_resp_valid, 0);
        @(posedge r_clk); #2;
        r_rst = 1'b0;
        clear_models();
        for (int i = 0; i < L + 2; i++) begin
            @(posedge r_clk); #1;
            check("midrst_no_resp", w_resp_valid, 0);
        end
        req4(1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        req4(1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        // Random traffic against the memory model, mostly on a small address
        // window so reads hit earlier writes.
        for (int n = 0; n < 60; n++) begin
            logic          we, junk, jwe;
            logic [AW-1:0] a, ja;
            logic [W-1:0]  d, jd;
            we   = 1'($urandom_range(0, 1));
            a    = AW'($urandom_range(0, 15));
            d    = W'($urandom);
            junk = 1'($urandom_range(0, 1));
            jwe  = 1'($urandom_range(0, 1));
            ja   = AW'($urandom_range(0, 15));
            jd   = W'($urandom);
            req4(we, a, d, junk, jwe, ja, jd);
            if ((n % 3) == 0) begin
                // An idle gap: nothing may respond.
                @(posedge r_clk); #1;
                check("gap_valid", w_resp_valid, 0);
            end
            if ((n % 4) == 0) begin
                req1(we, a, d);
                req1(1'b0, a, 8'h00);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_interface.md
Name: ram_interface

Overview:
- Backing-memory stage directly downstream of the cache control logic.
- Consumes the cache's RAM read/write requests (RAM_we path, miss fills) and produces data_from_RAM with a fixed, parameterised access latency.
- Models main memory as an internal storage array behind a single-outstanding request/response handshake, so the cache's done logic sees realistic multi-cycle misses.

Parameters:
- WIDTH, 8, data word width in bits; must match the cache WIDTH.
- ADDR_WIDTH, 8, word address width; storage depth is 2**ADDR_WIDTH words.
- LATENCY, 4, cycles from request acceptance to response; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present this cycle.
- req_we  input  1  1 = write, 0 = read; sampled with req_valid.
- req_addr  input  ADDR_WIDTH  word address.
- req_data  input  WIDTH  write data; ignored for reads.
- req_ready  output  1  block can accept a request this cycle.
- resp_valid  output  1  one-cycle pulse marking request completion.
- resp_data  output  WIDTH  read data; valid only while resp_valid=1.
- busy  output  1  request outstanding; equals the inverse of req_ready.

Behaviour:
- Reset:
  - Asynchronous, active-high: state goes to IDLE, latency counter clears to 0, and the capture registers clear to 0.
  - All storage words reset to 0.
  - Output reset values: req_ready=1, resp_valid=0, resp_data=0, busy=0.
- States:
  - IDLE: req_ready=1.
  - WAIT: counting down the access latency.
  - RESP: resp_valid=1.
- Handshake:
  - A request is accepted on any rising edge where req_valid=1 and req_ready=1.
  - req_valid while req_ready=0 is ignored; it is not queued.
  - On acceptance, req_we, req_addr and req_data are captured. Later input changes have no effect on the outstanding request.
- Transitions:
  - On acceptance with LATENCY=1: IDLE->RESP.
  - On acceptance with LATENCY>1: IDLE->WAIT, with counter = LATENCY-1.
  - In WAIT, the counter decrements each cycle. WAIT->RESP on the edge where the counter equals 1.
  - RESP->IDLE unconditionally after one cycle.
- Latency:
  - If the handshake occurs in cycle N, resp_valid=1 in exactly cycle N+LATENCY.
  - req_ready=0 in cycles N+1 through N+LATENCY.
  - The next acceptance can occur no earlier than cycle N+LATENCY+1.
- Array access: performed on the edge entering RESP.
  - Write: storage[addr] <= captured data; resp_data=0 during RESP. The write is acknowledged by resp_valid.
  - Read: resp_data <= storage[addr], and it is held only during RESP. resp_data returns to 0 when RESP is left.
- Ordering:
  - A read issued after a write's resp_valid returns the written value.
  - There is no possibility of overlap because only one request is outstanding.
- Reset mid-operation: an outstanding request is aborted with no response.
  - A pending write that has not reached RESP is discarded, and storage is unchanged apart from the reset clearing.
  - A write already committed before the reset is also lost, because reset clears storage.
- Counter width: 8 bits. LATENCY=0 or LATENCY>255 is illegal and must be flagged by an elaboration-time check.
- Address wrap: none needed, since every ADDR_WIDTH value maps to a valid word.
- resp_valid is never asserted for two consecutive cycles.

Test Plan:
1. Reset then idle: assert rst asynchronously mid-cycle -> req_ready=1, resp_valid=0, resp_data=0 immediately, with no clock edge needed.
2. Write-then-read, LATENCY=4: write 0xA5 to addr 0x12 accepted in cycle 10 -> resp_valid=1 only in cycle 14 with resp_data=0, and req_ready=0 in cycles 11-14. Read of 0x12 accepted in cycle 15 -> resp_valid in cycle 19 with resp_data=0xA5.
3. Minimum latency, LATENCY=1: read of unwritten addr 0x00 accepted in cycle 3 -> resp_valid in cycle 4 with resp_data=0x00, and req_ready=1 again in cycle 5.
4. Ignored request while busy: a second req_valid (write 0x3C to 0x12) held during WAIT, then dropped before IDLE -> it is never accepted, and a later read of 0x12 returns the prior value 0xA5.
5. Input stability: after acceptance of a read of 0x12, change req_addr to 0x34 during WAIT -> response data is storage[0x12].
6. Reset mid-operation: write 0x77 to 0x20 accepted, then rst pulsed 2 cycles later (LATENCY=4) -> no resp_valid. After reset, a read of 0x20 returns 0x00.
